jpeg_mcu_scheduler: RTL and testbench

Sequences 8x8 blocks of each MCU through the encoder's shared DCT/quantize/entropy datapath for one image. It walks the block order of the MCU (4:2:0 or 4:4:4) and issues one start pulse per block when the input buffer holds a block. It waits for the datapath's done, counts MCUs, clears the DC predictors at image start and signals end-of-image. It sits between the block input buffer and the datapath, in the `clk` domain.

---
 rtl/jpeg_mcu_scheduler.sv | 139 +++++++++++++
 tb/tb_jpeg_mcu_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_mcu_scheduler.sv
// jpeg_mcu_scheduler: walks the blocks of each MCU through the
// shared DCT/quant/entropy datapath and tracks image progress.
module jpeg_mcu_scheduler #(
  parameter int MCU_W      = 16,
  parameter bit CHROMA_420 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [MCU_W-1:0] cfg_mcu_count,
  output logic             cfg_ready,
  input  logic             abort,
  input  logic             blk_avail,
  output logic             dp_start,
  input  logic             dp_done,
  output logic [2:0]       blk_idx,
  output logic [1:0]       comp_id,
  output logic             qtab_sel,
  output logic             dc_pred_clr,
  output logic [MCU_W-1:0] mcu_done_cnt,
  output logic             eoi,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WAIT,
    S_ISSUE,
    S_RUN,
    S_EOI
  } state_e;

  localparam logic [2:0] IDX_CB = CHROMA_420 ? 3'd4 : 3'd1;
  localparam logic [2:0] IDX_CR = CHROMA_420 ? 3'd5 : 3'd2;
  localparam logic [2:0] LAST   = IDX_CR;

  state_e           state_q;
  logic [2:0]       blk_q;
  logic [MCU_W-1:0] cnt_q;
  logic [MCU_W-1:0] total_q;
  logic             err_q;
  logic             start_q;
  logic             clr_q;
  logic             eoi_q;
  logic [MCU_W-1:0] cnt_d;

  assign cnt_d = cnt_q + MCU_W'(1);

  // Block sequencer FSM with registered pulse and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      blk_q   <= 3'd0;
      cnt_q   <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      clr_q   <= 1'b0;
      eoi_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      clr_q   <= 1'b0;
      eoi_q   <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        blk_q   <= 3'd0;
      end else begin
        if (dp_done && state_q != S_RUN)
          err_q <= 1'b1;
        unique case (state_q)
          S_IDLE: begin
            if (cfg_valid) begin
              if (cfg_mcu_count == '0) begin
                err_q <= 1'b1;
              end else begin
                total_q <= cfg_mcu_count;
                blk_q   <= 3'd0;
                cnt_q   <= '0;
                err_q   <= 1'b0;
                clr_q   <= 1'b1;
                state_q <= S_CLR;
              end
            end
          end
          S_CLR: state_q <= S_WAIT;
          S_WAIT: begin
            if (blk_avail) begin
              start_q <= 1'b1;
              state_q <= S_ISSUE;
            end
          end
          S_ISSUE: state_q <= S_RUN;
          S_RUN: begin
            if (dp_done) begin
              if (blk_q != LAST) begin
                blk_q   <= blk_q + 3'd1;
                state_q <= S_WAIT;
              end else begin
                blk_q <= 3'd0;
                cnt_q <= cnt_d;
                if (cnt_d == total_q) begin
                  eoi_q   <= 1'b1;
                  state_q <= S_EOI;
                end else begin
                  state_q <= S_WAIT;
                end
              end
            end
          end
          S_EOI: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Component / quant-table decode of the block in flight
  always_comb begin
    comp_id = 2'd0;
    unique case (1'b1)
      (blk_q == IDX_CB): comp_id = 2'd1;
      (blk_q == IDX_CR): comp_id = 2'd2;
      default:           comp_id = 2'd0;
    endcase
  end

  assign qtab_sel     = (comp_id != 2'd0);
  assign cfg_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign dp_start     = start_q;
  assign dc_pred_clr  = clr_q;
  assign eoi          = eoi_q;
  assign err          = err_q;
  assign blk_idx      = blk_q;
  assign mcu_done_cnt = cnt_q;

endmodule

// File: tb/tb_jpeg_mcu_scheduler.sv
// tb_jpeg_mcu_scheduler: table-driven images on a 4:2:0 and a
// 4:4:4 instance, plus starve, error, abort and reset sequences.
module tb_jpeg_mcu_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid[2];
  logic [15:0] cfg_cnt[2];
  logic        abort_s[2];
  logic        blk_avail[2];
  logic        done_auto[2];
  logic        done_man[2];
  logic        dp_done[2];
  logic        auto_en[2];
  logic        cfg_ready[2];
  logic        dp_start[2];
  logic        qtab[2];
  logic        clr[2];
  logic        eoi[2];
  logic        busy[2];
  logic        err[2];
  logic [2:0]  blk_idx[2];
  logic [1:0]  comp[2];
  logic [15:0] mcnt[2];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_start[2];
  int n_clr[2];
  int n_eoi[2];
  int last_done_cyc[2];
  logic [15:0] prev_cnt[2];

  typedef struct packed {
    logic [2:0] idx;
    logic [1:0] comp;
    logic       q;
  } exp_t;

  exp_t expq[2][$];

  typedef struct {
    int u;
    int cnt;
    int starts;
  } vec_t;

  vec_t tbl[4];

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  jpeg_mcu_scheduler #(.MCU_W(16), .CHROMA_420(1'b1)) u420 (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid[0]), .cfg_mcu_count(cfg_cnt[0]),
    .cfg_ready(cfg_ready[0]), .abort(abort_s[0]),
    .blk_avail(blk_avail[0]), .dp_start(dp_start[0]),
    .dp_done(dp_done[0]), .blk_idx(blk_idx[0]),
    .comp_id(comp[0]), .qtab_sel(qtab[0]),
    .dc_pred_clr(clr[0]), .mcu_done_cnt(mcnt[0]),
    .eoi(eoi[0]), .busy(busy[0]), .err(err[0])
  );

  jpeg_mcu_scheduler #(.MCU_W(16), .CHROMA_420(1'b0)) u444 (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid[1]), .cfg_mcu_count(cfg_cnt[1]),
    .cfg_ready(cfg_ready[1]), .abort(abort_s[1]),
    .blk_avail(blk_avail[1]), .dp_start(dp_start[1]),
    .dp_done(dp_done[1]), .blk_idx(blk_idx[1]),
    .comp_id(comp[1]), .qtab_sel(qtab[1]),
    .dc_pred_clr(clr[1]), .mcu_done_cnt(mcnt[1]),
    .eoi(eoi[1]), .busy(busy[1]), .err(err[1])
  );

  task automatic check(input string nm, input int u,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[u%0d]: got %0d want %0d",
               nm, u, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_tb
    assign dp_done[g] = done_auto[g] | done_man[g];

    // datapath model: done 4 cycles after each start
    initial begin : resp
      forever begin
        @(negedge clk);
        if (rst_n && dp_start[g] && auto_en[g]) begin
          repeat (4) @(posedge clk);
          #1 done_auto[g] = 1'b1;
          @(posedge clk);
          #1 done_auto[g] = 1'b0;
        end
      end
    end

    // scoreboard pop and pulse bookkeeping
    initial begin : mon
      exp_t e;
      logic [2:0] last_idx;
      last_idx = 3'd0;
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (dp_start[g]) begin
            n_start[g]++;
            last_idx = blk_idx[g];
            if (expq[g].size() == 0) begin
              n_vec++;
              n_bad++;
              $display("FAIL start_extra[u%0d]: got idx %0d",
                       g, blk_idx[g]);
            end else begin
              e = expq[g].pop_front();
              check("blk_idx", g, blk_idx[g], e.idx);
              check("comp_id", g, comp[g], e.comp);
              check("qtab_sel", g, qtab[g], e.q);
            end
          end
          if (done_auto[g]) begin
            check("idx_stable", g, blk_idx[g], last_idx);
            last_done_cyc[g] = cyc;
          end
          if (clr[g]) n_clr[g]++;
          if (eoi[g]) begin
            n_eoi[g]++;
            check("eoi_lat", g, cyc - last_done_cyc[g], 1);
          end
          if (busy[g] && mcnt[g] != prev_cnt[g] &&
              mcnt[g] != 16'd0)
            check("cnt_step", g, mcnt[g], prev_cnt[g] + 1);
          prev_cnt[g] = mcnt[g];
        end
      end
    end
  end

  task automatic clear_cnt(input int u);
    n_start[u] = 0;
    n_clr[u]   = 0;
    n_eoi[u]   = 0;
  endtask

  task automatic push_exp(input int u, input int cnt);
    exp_t e;
    int nb;
    nb = (u == 0) ? 6 : 3;
    for (int m = 0; m < cnt; m++) begin
      for (int b = 0; b < nb; b++) begin
        e.idx = 3'(b);
        if (u == 0)
          e.comp = (b < 4) ? 2'd0 : 2'(b - 3);
        else
          e.comp = 2'(b);
        e.q = (e.comp != 2'd0);
        expq[u].push_back(e);
      end
    end
  endtask

  task automatic handshake(input int u, input int cnt);
    @(posedge clk);
    #1;
    cfg_valid[u] = 1'b1;
    cfg_cnt[u]   = 16'(cnt);
    @(negedge clk);
    check("cfg_ready", u, cfg_ready[u], 1);
    @(posedge clk);
    #1 cfg_valid[u] = 1'b0;
  endtask

  task automatic wait_eoi(input int u, input int budget);
    int k;
    k = 0;
    while (n_eoi[u] == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_start(input int u);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!dp_start[u] && k < 40);
    check("start_seen", u, dp_start[u], 1);
  endtask

  task automatic run_image(input int u, input int cnt,
                           input int starts);
    clear_cnt(u);
    push_exp(u, cnt);
    blk_avail[u] = 1'b1;
    auto_en[u]   = 1'b1;
    handshake(u, cnt);
    @(negedge clk);
    check("clr_t1", u, clr[u], 1);
    @(negedge clk);
    check("start_t2", u, dp_start[u], 0);
    @(negedge clk);
    check("start_t3", u, dp_start[u], 1);
    wait_eoi(u, 400);
    @(negedge clk);
    check("n_clr", u, n_clr[u], 1);
    check("n_start", u, n_start[u], starts);
    check("n_eoi", u, n_eoi[u], 1);
    check("mcu_cnt", u, mcnt[u], cnt);
    check("idle_busy", u, busy[u], 0);
    check("idle_ready", u, cfg_ready[u], 1);
    check("err", u, err[u], 0);
    check("q_empty", u, expq[u].size(), 0);
  endtask

  task automatic check_reset_vals(input int u);
    check("rst_ready", u, cfg_ready[u], 1);
    check("rst_busy", u, busy[u], 0);
    check("rst_start", u, dp_start[u], 0);
    check("rst_clr", u, clr[u], 0);
    check("rst_eoi", u, eoi[u], 0);
    check("rst_err", u, err[u], 0);
    check("rst_idx", u, blk_idx[u], 0);
    check("rst_cnt", u, mcnt[u], 0);
    check("rst_comp", u, comp[u], 0);
    check("rst_qtab", u, qtab[u], 0);
  endtask

  initial begin
    tbl[0] = '{0, 1, 6};
    tbl[1] = '{1, 3, 9};
    tbl[2] = '{0, 2, 12};
    tbl[3] = '{1, 1, 3};
    for (int u = 0; u < 2; u++) begin
      cfg_valid[u] = 1'b0;
      cfg_cnt[u]   = 16'd0;
      abort_s[u]   = 1'b0;
      blk_avail[u] = 1'b0;
      done_auto[u] = 1'b0;
      done_man[u]  = 1'b0;
      auto_en[u]   = 1'b0;
      prev_cnt[u]  = 16'd0;
      last_done_cyc[u] = 0;
      clear_cnt(u);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals(0);
    check_reset_vals(1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      run_image(tbl[i].u, tbl[i].cnt, tbl[i].starts);

    // zero-count handshake
    handshake(0, 0);
    check("zero_err", 0, err[0], 1);
    check("zero_busy", 0, busy[0], 0);
    check("zero_clr", 0, clr[0], 0);

    // starved input
    clear_cnt(0);
    push_exp(0, 1);
    blk_avail[0] = 1'b0;
    auto_en[0]   = 1'b1;
    handshake(0, 1);
    @(negedge clk);
    check("err_cleared", 0, err[0], 0);
    repeat (20) @(negedge clk);
    check("starved", 0, n_start[0], 0);
    @(posedge clk);
    #1 blk_avail[0] = 1'b1;
    @(negedge clk);
    check("starve_w0", 0, dp_start[0], 0);
    @(negedge clk);
    check("starve_w1", 0, dp_start[0], 1);
    wait_eoi(0, 400);
    @(negedge clk);
    check("starve_n", 0, n_start[0], 6);
    check("starve_eoi", 0, n_eoi[0], 1);

    // dp_done while waiting
    clear_cnt(0);
    push_exp(0, 1);
    blk_avail[0] = 1'b0;
    handshake(0, 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 done_man[0] = 1'b1;
    @(posedge clk);
    #1 done_man[0] = 1'b0;
    @(negedge clk);
    check("wait_err", 0, err[0], 1);
    check("wait_idx", 0, blk_idx[0], 0);
    check("wait_busy", 0, busy[0], 1);
    blk_avail[0] = 1'b1;
    wait_eoi(0, 400);
    @(negedge clk);
    check("werr_n", 0, n_start[0], 6);
    check("werr_cnt", 0, mcnt[0], 1);
    check("werr_sticky", 0, err[0], 1);

    // abort in RUN of block 3, MCU 2, with dp_done
    clear_cnt(0);
    push_exp(0, 2);
    void'(expq[0].pop_back());
    void'(expq[0].pop_back());
    auto_en[0] = 1'b0;
    handshake(0, 3);
    for (int i = 0; i < 10; i++) begin
      wait_start(0);
      @(posedge clk);
      #1;
      done_man[0] = 1'b1;
      if (i == 9) abort_s[0] = 1'b1;
      @(posedge clk);
      #1;
      done_man[0] = 1'b0;
      abort_s[0]  = 1'b0;
    end
    @(negedge clk);
    check("ab_busy", 0, busy[0], 0);
    check("ab_idx", 0, blk_idx[0], 0);
    check("ab_cnt", 0, mcnt[0], 1);
    check("ab_err", 0, err[0], 0);
    repeat (5) @(negedge clk);
    check("ab_eoi", 0, n_eoi[0], 0);
    check("ab_q", 0, expq[0].size(), 0);
    check("ab_n", 0, n_start[0], 10);
    run_image(0, 1, 6);

    // async reset mid-RUN on the 4:4:4 instance
    clear_cnt(1);
    push_exp(1, 2);
    auto_en[1]   = 1'b1;
    blk_avail[1] = 1'b1;
    handshake(1, 2);
    wait_start(1);
    wait_start(1);
    @(posedge clk);
    #2;
    check("pre_idx", 1, blk_idx[1], 1);
    check("pre_busy", 1, busy[1], 1);
    auto_en[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals(1);
    expq[1].delete();
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b1;
    run_image(1, 1, 3);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
